// File: rtl/lpfilter_pkg.sv
// Shared lpfilter definitions: sequencer state encoding and the default
// widths used by the controller, the FIR core and the lpfilter top.
package lpfilter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    localparam int unsigned LPF_IWIDTH   = 16;
    localparam int unsigned LPF_OWIDTH   = 32;
    localparam int unsigned LPF_CLENGTH  = 21;
    localparam int unsigned LPF_FRAMELEN = 256;
    localparam int unsigned LPF_CNTWIDTH = 16;

endpackage

// File: rtl/lpfilter_ctrl.sv
// Frame sequencer for the transposed-form FIR core: clear the delay line,
// stream one frame in, drain the convolution tail, all under backpressure.
module lpfilter_ctrl
    import lpfilter_pkg::*;
#(
    parameter int unsigned C_IWIDTH   = LPF_IWIDTH,
    parameter int unsigned C_OWIDTH   = LPF_OWIDTH,
    parameter int unsigned C_CLENGTH  = LPF_CLENGTH,
    parameter int unsigned C_FRAMELEN = LPF_FRAMELEN,
    parameter int unsigned C_CNTWIDTH = LPF_CNTWIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic                si_valid,
    output logic                si_ready,
    input  logic [C_IWIDTH-1:0] si_data,
    output logic                mo_valid,
    input  logic                mo_ready,
    output logic [C_OWIDTH-1:0] mo_data,
    output logic                fir_en,
    output logic [C_IWIDTH-1:0] fir_din,
    input  logic [C_OWIDTH-1:0] fir_dout
);

    localparam bit HAS_TAIL = (C_CLENGTH > 1);
    localparam logic [C_CNTWIDTH-1:0] CLR_LAST = C_CNTWIDTH'(C_CLENGTH - 1);
    localparam logic [C_CNTWIDTH-1:0] RUN_LAST = C_CNTWIDTH'(C_FRAMELEN - 1);
    localparam logic [C_CNTWIDTH-1:0] FL_LAST  =
        C_CNTWIDTH'(HAS_TAIL ? C_CLENGTH - 2 : 0);

    state_e                state_q, state_d;
    logic [C_CNTWIDTH-1:0] cnt_q, cnt_d;
    logic                  mo_valid_q, mo_valid_d;
    logic                  done_q, done_d;

    logic                  slot_free;
    logic                  fir_en_c;
    logic                  si_ready_c;
    logic [C_IWIDTH-1:0]   fir_din_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mo_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mo_valid_q <= mo_valid_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mo_valid_d = mo_valid_q;
        done_d     = 1'b0;
        slot_free  = !mo_valid_q || mo_ready;
        fir_en_c   = 1'b0;
        si_ready_c = 1'b0;
        fir_din_c  = '0;

        if (mo_valid_q && mo_ready) begin
            mo_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // Hold off while a previous frame's last result is unread.
                fir_en_c = !mo_valid_q;
                if (fir_en_c) begin
                    if (cnt_q == CLR_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                si_ready_c = slot_free;
                fir_en_c   = si_valid && slot_free;
                fir_din_c  = si_data;
                if (fir_en_c) begin
                    mo_valid_d = 1'b1;
                    if (cnt_q == RUN_LAST) begin
                        cnt_d = '0;
                        if (HAS_TAIL) begin
                            state_d = ST_FLUSH;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                fir_en_c = slot_free;
                if (fir_en_c) begin
                    mo_valid_d = 1'b1;
                    if (cnt_q == FL_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign si_ready = si_ready_c;
    assign mo_valid = mo_valid_q;
    assign mo_data  = fir_dout;
    assign fir_en   = fir_en_c;
    assign fir_din  = fir_din_c;

endmodule

// File: tb/tb_lpfilter_ctrl.sv
// Bench for lpfilter_ctrl with a behavioural 21-tap FIR sibling and a
// convolution reference model of the expected result stream.
module tb_lpfilter_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        si_valid;
    logic        si_ready;
    logic [15:0] si_data;
    logic        mo_valid;
    logic        mo_ready;
    logic [31:0] mo_data;
    logic        fir_en;
    logic [15:0] fir_din;
    logic [31:0] fir_dout;

    int n_checks = 0;
    int n_errors = 0;

    int h [21] = '{6, 0, -4, -3, 5, 6, -6, -13, 7, 44, 64,
                   44, 7, -13, -6, 6, 5, -3, -4, 0, 6};
    int imp [24] = '{6, 0, -4, -3, 5, 6, -6, -13, 7, 44, 64, 44,
                     7, -13, -6, 6, 5, -3, -4, 0, 6, 0, 0, 0};

    int   stim [$];
    int   got  [$];
    int   exp_q [$];
    int   done_pres;
    logic seed;
    logic prev_stall;
    logic [31:0] prev_data;
    int   zl [20];

    always #5 clk = ~clk;

    lpfilter_ctrl #(
        .C_IWIDTH  (16),
        .C_OWIDTH  (32),
        .C_CLENGTH (21),
        .C_FRAMELEN(4),
        .C_CNTWIDTH(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .si_valid(si_valid),
        .si_ready(si_ready),
        .si_data (si_data),
        .mo_valid(mo_valid),
        .mo_ready(mo_ready),
        .mo_data (mo_data),
        .fir_en  (fir_en),
        .fir_din (fir_din),
        .fir_dout(fir_dout)
    );

    // Sibling FIR core: registered output, no reset (stale contents).
    function automatic int fir_eval(input logic [15:0] din);
        int s;
        s = h[0] * int'($signed(din));
        for (int k = 1; k < 21; k++) s += h[k] * zl[k-1];
        return s;
    endfunction

    always @(posedge clk) begin
        if (seed) begin
            for (int i = 0; i < 20; i++)
                zl[i] <= int'($urandom_range(2000, 0)) - 1000;
            fir_dout <= $urandom;
        end else if (fir_en) begin
            fir_dout <= 32'(fir_eval(fir_din));
            zl[0] <= int'($signed(fir_din));
            for (int i = 1; i < 20; i++) zl[i] <= zl[i-1];
        end
    end

    task automatic chk(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, req);
        end
    endtask

    // Result collector and stall-cycle checks.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) chk("mo_data_hold", mo_data, prev_data);
            if (mo_valid && !mo_ready) begin
                chk("stall_fir_en", fir_en, 0);
                chk("stall_si_ready", si_ready, 0);
            end
            if (mo_valid && mo_ready) got.push_back($signed(mo_data));
            if (done) begin
                chk("done_with_valid", mo_valid, 1);
                done_pres = got.size() + ((mo_valid && !mo_ready) ? 1 : 0);
            end
        end
        prev_stall <= !rst && mo_valid && !mo_ready;
        prev_data  <= mo_data;
    end

    function automatic void build_exp();
        int n;
        int s;
        n = stim.size();
        exp_q.delete();
        for (int i = 0; i < n + 20; i++) begin
            s = 0;
            for (int k = 0; k < 21; k++)
                if (i - k >= 0 && i - k < n) s += h[k] * stim[i-k];
            exp_q.push_back(s);
        end
    endfunction

    task automatic cmp_stream(input string tag, input int e [$]);
        chk({tag, "_count"}, got.size(), e.size());
        chk({tag, "_done_pos"}, done_pres, e.size());
        for (int i = 0; i < e.size() && i < got.size(); i++)
            chk($sformatf("%s_res%0d", tag, i), got[i], e[i]);
    endtask

    task automatic run_frame(input string tag, input bit do_start,
                             input bit toggle, input int gap_at,
                             input bit poke, input bit chain,
                             output int first_rdy);
        int idx, cyc, gap;
        bit fin, dseen, acc, gcyc;
        idx = 0; cyc = 1; gap = 0;
        fin = 0; dseen = 0; first_rdy = -1;
        got.delete();
        done_pres = -1;
        if (do_start) begin
            start = 1'b1; mo_ready = 1'b1; si_valid = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        while (!fin && cyc < 400) begin
            gcyc = (gap_at >= 0) && (idx == gap_at) && (gap < 5);
            si_valid = (idx < stim.size()) && !gcyc;
            si_data  = (idx < stim.size()) ? 16'(stim[idx]) : 16'h0;
            mo_ready = toggle ? cyc[0] : 1'b1;
            start    = (chain && done) || (poke && busy && (cyc % 3 == 0));
            @(negedge clk);
            if (si_ready && first_rdy < 0) first_rdy = cyc;
            acc = si_valid && si_ready;
            if (gcyc) begin
                chk({tag, "_gap_fir_en"}, fir_en, 0);
                if (gap > 0) chk({tag, "_gap_mo_valid"}, mo_valid, 0);
            end
            if (done) dseen = 1;
            fin = dseen && !(mo_valid && !mo_ready);
            @(posedge clk); #1;
            if (acc) idx++;
            if (gcyc) gap++;
            cyc++;
        end
        start = 1'b0; si_valid = 1'b0; mo_ready = 1'b1;
        chk({tag, "_completed"}, fin, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_si_ready"}, si_ready, 0);
        chk({tag, "_mo_valid"}, mo_valid, 0);
        chk({tag, "_fir_en"}, fir_en, 0);
        chk({tag, "_fir_din"}, fir_din, 0);
        chk({tag, "_mo_data"}, mo_data, fir_dout);
    endtask

    initial begin
        int fr;
        int e [$];
        int nacc;
        int k;
        rst = 1'b1; seed = 1'b1; start = 1'b0;
        si_valid = 1'b0; si_data = '0; mo_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        seed = 1'b0; rst = 1'b0;

        // Impulse on a randomly seeded core.
        stim = '{1, 0, 0, 0};
        e.delete();
        for (int i = 0; i < 24; i++) e.push_back(imp[i]);
        run_frame("impulse", 1, 0, -1, 0, 0, fr);
        chk("impulse_first_ready", fr, 22);
        cmp_stream("impulse", e);

        // Back-to-back: second start lands in the done cycle.
        run_frame("b2b_a", 1, 0, -1, 0, 1, fr);
        cmp_stream("b2b_a", e);
        stim = '{2, 0, 0, 0};
        e.delete();
        for (int i = 0; i < 24; i++) e.push_back(2 * imp[i]);
        run_frame("b2b_b", 0, 0, -1, 0, 0, fr);
        chk("b2b_b_first_ready", fr, 22);
        cmp_stream("b2b_b", e);

        // Backpressure with ready toggling every cycle.
        stim = '{100, 100, 100, 100};
        build_exp();
        run_frame("bp", 1, 1, -1, 0, 0, fr);
        cmp_stream("bp", exp_q);

        // Source starvation mid-frame with random samples.
        stim.delete();
        for (int i = 0; i < 4; i++)
            stim.push_back(int'($urandom_range(2000, 0)) - 1000);
        build_exp();
        run_frame("starve", 1, 0, 2, 0, 0, fr);
        cmp_stream("starve", exp_q);

        // Reset asynchronously during RUN after two samples.
        start = 1'b1; mo_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; si_valid = 1'b1; si_data = 16'd777;
        nacc = 0; k = 0;
        while (nacc < 2 && k < 100) begin
            @(negedge clk);
            if (si_valid && si_ready) nacc++;
            @(posedge clk); #1;
            k++;
        end
        chk("rst_mid_samples", nacc, 2);
        chk("rst_mid_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_mid");
        si_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        stim = '{1, 0, 0, 0};
        e.delete();
        for (int i = 0; i < 24; i++) e.push_back(imp[i]);
        run_frame("after_rst", 1, 0, -1, 0, 0, fr);
        cmp_stream("after_rst", e);

        // Start pulses while busy must be ignored.
        stim.delete();
        for (int i = 0; i < 4; i++)
            stim.push_back(int'($urandom_range(600, 0)) - 300);
        build_exp();
        run_frame("poke", 1, 0, -1, 1, 0, fr);
        cmp_stream("poke", exp_q);
        repeat (3) @(posedge clk);
        #1 chk("poke_idle_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
